ctrl_pipeline: RTL and testbench
================================

CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

Interface
REQ-001 Parameter ALUCTRL_W, default 4, width of ALU control code; values below 4 are illegal.
REQ-002 Parameter RADDR_W, default 5, register-address width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 OpD, funct7D  in  7 each  decode-stage opcode and funct7; funct3D  in  3  decode-stage funct3.
REQ-006 Rs1D, Rs2D, RdD  in  RADDR_W each  decode-stage register addresses.
REQ-007 FlushE  in  1  branch/jump taken; turns the next Execute slot into a bubble.
REQ-008 ImmSrcD  out  3  combinational immediate select: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-009 IllegalD  out  1  combinational; current decode opcode/funct is unsupported.
REQ-010 StallD  out  1  combinational load-use hazard; upstream holds PC and the IF/ID register.
REQ-011 Execute outputs: RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE (1 each), ResultSrcE (2), ALUControlE (ALUCTRL_W), RdE (RADDR_W).
REQ-012 Memory outputs: RegWriteM, MemWriteM (1 each), ResultSrcM (2), RdM (RADDR_W).
REQ-013 Writeback outputs: RegWriteW (1), ResultSrcW (2), RdW (RADDR_W).

Function
REQ-014 Decode SHALL cover R 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011, jal 1101111, jalr 1100111, lui 0110111.
REQ-015 ResultSrc encoding SHALL be 00 ALU, 01 memory, 10 PC+4; loads 01, jal/jalr 10, all else 00.
REQ-016 ALUControl SHALL encode 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1010 pass-B (lui), zero-extended to ALUCTRL_W.
REQ-017 sub SHALL be chosen only for R-type funct3 000 with funct7[5]=1; sra for funct3 101 with funct7[5]=1 (R and I-type); loads/stores/jalr use add; branches use sub.
REQ-018 Decoded controls SHALL reach Execute outputs 1 cycle, Memory 2 cycles and Writeback 3 cycles after presentation at decode.
REQ-019 StallD SHALL be 1 when ResultSrcE=01 and RegWriteE=1 and RdE!=0 and (RdE==Rs1D or RdE==Rs2D); Rs2D compared for all opcodes.
REQ-020 When StallD=1 or FlushE=1, the Execute register SHALL load a bubble (all enables 0, ResultSrcE 00, ALUControlE 0, RdE 0); Memory and Writeback advance normally.
REQ-021 Stall and flush in the same cycle SHALL yield one bubble; no decode state is held internally.
REQ-022 Illegal instruction: IllegalD=1, Execute loads a bubble, ImmSrcD=000.
REQ-023 Writes targeting Rd=0 SHALL pass RegWrite through unchanged; x0 suppression belongs to the register file.

Reset
REQ-024 While rst=0, all Execute, Memory and Writeback registers SHALL be 0 asynchronously; first decode is captured on the first rising edge after rst rises.
REQ-025 Reset asserted mid-instruction SHALL discard all in-flight controls with no partial writes.

Configuration
REQ-026 With M_EXT_EN defined, R-type funct7=0000001 SHALL decode funct3 000 to 1011 mul, 001 to 1100 mulh, 100 to 1101 div, 110 to 1110 rem; other funct3 values are illegal.
REQ-027 Without M_EXT_EN, funct7=0000001 SHALL raise IllegalD and bubble Execute.

Structure
REQ-028 Opcode, ResultSrc, ImmSrc and ALUControl encodings SHALL live in shared package ctrl_pkg.
REQ-029 Combinational decode SHALL be sub-module ctrl_decode; ctrl_pipeline holds the stage registers and hazard logic.

Verification
REQ-030 add x3,x1,x2 (0110011/000/0000000), rd=3 -> ALUControlE=0000, RegWriteE=1 after 1 cycle; RegWriteW=1, RdW=3 after 3 cycles.
REQ-031 lw x5 in Execute, next decode Rs1D=5 -> StallD=1, next cycle all Execute enables 0; lw reaches MemM with ResultSrcM=01.
REQ-032 beq at decode with FlushE=1 the same cycle -> BranchE=0, RegWriteE=0 next cycle.
REQ-033 rst low while sw is in Memory -> MemWriteM=0 immediately, before any clock edge.
REQ-034 funct7=0000001, funct3=000: with M_EXT_EN -> ALUControlE=1011; without -> IllegalD=1 and bubble.
REQ-035 jal rd=1 -> ImmSrcD=011, JumpE=1, ResultSrcE=10; lui -> ImmSrcD=100, ALUControlE=1010, ALUSrcE=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the control pipeline: opcodes, result/immediate selects, ALU codes
// and the decoded control bundle.
package ctrl_pkg;

    typedef enum logic [6:0] {
        OpR      = 7'b0110011,
        OpImm    = 7'b0010011,
        OpLoad   = 7'b0000011,
        OpStore  = 7'b0100011,
        OpBranch = 7'b1100011,
        OpJal    = 7'b1101111,
        OpJalr   = 7'b1100111,
        OpLui    = 7'b0110111
    } opcode_e;

    typedef enum logic [1:0] {
        ResAlu = 2'b00,
        ResMem = 2'b01,
        ResPc4 = 2'b10
    } result_src_e;

    typedef enum logic [2:0] {
        ImmI = 3'b000,
        ImmS = 3'b001,
        ImmB = 3'b010,
        ImmJ = 3'b011,
        ImmU = 3'b100
    } imm_src_e;

    typedef enum logic [3:0] {
        AluAdd  = 4'b0000,
        AluSub  = 4'b0001,
        AluAnd  = 4'b0010,
        AluOr   = 4'b0011,
        AluXor  = 4'b0100,
        AluSlt  = 4'b0101,
        AluSltu = 4'b0110,
        AluSll  = 4'b0111,
        AluSrl  = 4'b1000,
        AluSra  = 4'b1001,
        AluPassB = 4'b1010,
        AluMul  = 4'b1011,
        AluMulh = 4'b1100,
        AluDiv  = 4'b1101,
        AluRem  = 4'b1110
    } alu_ctrl_e;

    typedef struct packed {
        logic        reg_write;
        logic        alu_src;
        logic        mem_write;
        logic        branch;
        logic        jump;
        result_src_e result_src;
        alu_ctrl_e   alu_ctrl;
    } ctrl_t;

    localparam ctrl_t CtrlBubble = ctrl_t'('0);

    // alt selects sub/sra (funct7[5]); callers decide whether alt is honoured
    function automatic alu_ctrl_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_ctrl_e res;
        case (funct3)
            3'b000:  res = alt ? AluSub : AluAdd;
            3'b001:  res = AluSll;
            3'b010:  res = AluSlt;
            3'b011:  res = AluSltu;
            3'b100:  res = AluXor;
            3'b101:  res = alt ? AluSra : AluSrl;
            3'b110:  res = AluOr;
            default: res = AluAnd;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode. Define M_EXT_EN to accept the multiply/divide subset
// (funct7 0000001); otherwise those encodings are flagged illegal.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output ctrl_t      ctrl,
    output imm_src_e   imm_src,
    output logic       illegal
);

    ctrl_t    ctrl_raw;
    imm_src_e imm_raw;
    logic     bad;

    always_comb begin
        ctrl_raw = CtrlBubble;
        imm_raw  = ImmI;
        bad      = 1'b0;
        case (op)
            OpR: begin
                ctrl_raw.reg_write = 1'b1;
                if (funct7 == 7'b0000000) begin
                    ctrl_raw.alu_ctrl = alu_from_funct3(funct3, 1'b0);
                end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    ctrl_raw.alu_ctrl = alu_from_funct3(funct3, 1'b1);
`ifdef M_EXT_EN
                end else if (funct7 == 7'b0000001) begin
                    case (funct3)
                        3'b000:  ctrl_raw.alu_ctrl = AluMul;
                        3'b001:  ctrl_raw.alu_ctrl = AluMulh;
                        3'b100:  ctrl_raw.alu_ctrl = AluDiv;
                        3'b110:  ctrl_raw.alu_ctrl = AluRem;
                        default: bad = 1'b1;
                    endcase
`endif
                end else begin
                    bad = 1'b1;
                end
            end
            OpImm: begin
                ctrl_raw.reg_write = 1'b1;
                ctrl_raw.alu_src   = 1'b1;
                // funct7 is only an opcode extension for the shifts; elsewhere it is immediate
                if (funct3 == 3'b001) begin
                    ctrl_raw.alu_ctrl = AluSll;
                    bad = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    ctrl_raw.alu_ctrl = alu_from_funct3(funct3, funct7[5]);
                    bad = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                end else begin
                    ctrl_raw.alu_ctrl = alu_from_funct3(funct3, 1'b0);
                end
            end
            OpLoad: begin
                ctrl_raw.reg_write  = 1'b1;
                ctrl_raw.alu_src    = 1'b1;
                ctrl_raw.result_src = ResMem;
            end
            OpStore: begin
                ctrl_raw.mem_write = 1'b1;
                ctrl_raw.alu_src   = 1'b1;
                imm_raw            = ImmS;
            end
            OpBranch: begin
                ctrl_raw.branch   = 1'b1;
                ctrl_raw.alu_ctrl = AluSub;
                imm_raw           = ImmB;
            end
            OpJal: begin
                ctrl_raw.reg_write  = 1'b1;
                ctrl_raw.jump       = 1'b1;
                ctrl_raw.result_src = ResPc4;
                imm_raw             = ImmJ;
            end
            OpJalr: begin
                ctrl_raw.reg_write  = 1'b1;
                ctrl_raw.jump       = 1'b1;
                ctrl_raw.alu_src    = 1'b1;
                ctrl_raw.result_src = ResPc4;
            end
            OpLui: begin
                ctrl_raw.reg_write = 1'b1;
                ctrl_raw.alu_src   = 1'b1;
                ctrl_raw.alu_ctrl  = AluPassB;
                imm_raw            = ImmU;
            end
            default: bad = 1'b1;
        endcase
    end

    assign illegal = bad;
    assign ctrl    = bad ? CtrlBubble : ctrl_raw;
    assign imm_src = bad ? ImmI : imm_raw;

endmodule

// File: rtl/ctrl_pipeline.sv
// Control path stage registers (Execute/Memory/Writeback) and load-use hazard detection.
// The M_EXT_EN macro is passed through to the decoder.
module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 4,
    parameter int unsigned RADDR_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           OpD,
    input  logic [2:0]           funct3D,
    input  logic [6:0]           funct7D,
    input  logic [RADDR_W-1:0]   Rs1D,
    input  logic [RADDR_W-1:0]   Rs2D,
    input  logic [RADDR_W-1:0]   RdD,
    input  logic                 FlushE,
    output logic [2:0]           ImmSrcD,
    output logic                 IllegalD,
    output logic                 StallD,
    output logic                 RegWriteE,
    output logic                 ALUSrcE,
    output logic                 MemWriteE,
    output logic                 BranchE,
    output logic                 JumpE,
    output logic [1:0]           ResultSrcE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic [RADDR_W-1:0]   RdE,
    output logic                 RegWriteM,
    output logic                 MemWriteM,
    output logic [1:0]           ResultSrcM,
    output logic [RADDR_W-1:0]   RdM,
    output logic                 RegWriteW,
    output logic [1:0]           ResultSrcW,
    output logic [RADDR_W-1:0]   RdW
);

    if (ALUCTRL_W < 4) begin : g_bad_aluctrl_w
        $error("ALUCTRL_W must be at least 4");
    end

    ctrl_t              dec_ctrl;
    imm_src_e           dec_imm;
    ctrl_t              ctrl_e_d;
    logic [RADDR_W-1:0] rd_e_d;
    logic               bubble;

    ctrl_decode u_decode (
        .op      (OpD),
        .funct3  (funct3D),
        .funct7  (funct7D),
        .ctrl    (dec_ctrl),
        .imm_src (dec_imm),
        .illegal (IllegalD)
    );

    assign ImmSrcD = dec_imm;

    // Rs2D is compared regardless of opcode: a false stall costs a cycle, a missed one is wrong
    assign StallD = (ResultSrcE == ResMem) && RegWriteE && (RdE != '0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

    assign bubble = StallD | FlushE | IllegalD;

    always_comb begin
        ctrl_e_d = dec_ctrl;
        rd_e_d   = RdD;
        if (bubble) begin
            ctrl_e_d = CtrlBubble;
            rd_e_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            MemWriteE   <= 1'b0;
            BranchE     <= 1'b0;
            JumpE       <= 1'b0;
            ResultSrcE  <= '0;
            ALUControlE <= '0;
            RdE         <= '0;
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= '0;
            RdM         <= '0;
            RegWriteW   <= 1'b0;
            ResultSrcW  <= '0;
            RdW         <= '0;
        end else begin
            RegWriteE   <= ctrl_e_d.reg_write;
            ALUSrcE     <= ctrl_e_d.alu_src;
            MemWriteE   <= ctrl_e_d.mem_write;
            BranchE     <= ctrl_e_d.branch;
            JumpE       <= ctrl_e_d.jump;
            ResultSrcE  <= ctrl_e_d.result_src;
            ALUControlE <= ALUCTRL_W'(ctrl_e_d.alu_ctrl);
            RdE         <= rd_e_d;
            RegWriteM   <= RegWriteE;
            MemWriteM   <= MemWriteE;
            ResultSrcM  <= ResultSrcE;
            RdM         <= RdE;
            RegWriteW   <= RegWriteM;
            ResultSrcW  <= ResultSrcM;
            RdW         <= RdM;
        end
    end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline; expectations follow M_EXT_EN when it is defined.
module tb_ctrl_pipeline;

    localparam logic [6:0] R_OP   = 7'b0110011;
    localparam logic [6:0] I_OP   = 7'b0010011;
    localparam logic [6:0] LD_OP  = 7'b0000011;
    localparam logic [6:0] ST_OP  = 7'b0100011;
    localparam logic [6:0] BR_OP  = 7'b1100011;
    localparam logic [6:0] JAL_OP = 7'b1101111;
    localparam logic [6:0] LUI_OP = 7'b0110111;

    logic       clk;
    logic       rst;
    logic [6:0] OpD, funct7D;
    logic [2:0] funct3D;
    logic [4:0] Rs1D, Rs2D, RdD;
    logic       FlushE;
    logic [2:0] ImmSrcD;
    logic       IllegalD, StallD;
    logic       RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE;
    logic [1:0] ResultSrcE;
    logic [3:0] ALUControlE;
    logic [4:0] RdE;
    logic       RegWriteM, MemWriteM;
    logic [1:0] ResultSrcM;
    logic [4:0] RdM;
    logic       RegWriteW;
    logic [1:0] ResultSrcW;
    logic [4:0] RdW;

    int total = 0;
    int bad   = 0;

    ctrl_pipeline #(.ALUCTRL_W(4), .RADDR_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .OpD         (OpD),
        .funct3D     (funct3D),
        .funct7D     (funct7D),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .RdD         (RdD),
        .FlushE      (FlushE),
        .ImmSrcD     (ImmSrcD),
        .IllegalD    (IllegalD),
        .StallD      (StallD),
        .RegWriteE   (RegWriteE),
        .ALUSrcE     (ALUSrcE),
        .MemWriteE   (MemWriteE),
        .BranchE     (BranchE),
        .JumpE       (JumpE),
        .ResultSrcE  (ResultSrcE),
        .ALUControlE (ALUControlE),
        .RdE         (RdE),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .RdM         (RdM),
        .RegWriteW   (RegWriteW),
        .ResultSrcW  (ResultSrcW),
        .RdW         (RdW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        OpD = op; funct3D = f3; funct7D = f7; Rs1D = rs1; Rs2D = rs2; RdD = rd;
        #1;
    endtask

    // Execute stage fully bubbled
    task automatic check_bubble(input string tag);
        check({tag, "_enables"}, {RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE}, 0);
        check({tag, "_res"}, ResultSrcE, 0);
        check({tag, "_alu"}, ALUControlE, 0);
        check({tag, "_rd"}, RdE, 0);
    endtask

    initial begin
        rst = 1'b0; FlushE = 1'b0;
        OpD = '0; funct3D = '0; funct7D = '0; Rs1D = '0; Rs2D = '0; RdD = '0;
        #3;
        check_bubble("reset_e");
        check("reset_m", {RegWriteM, MemWriteM, ResultSrcM, RdM}, 0);
        check("reset_w", {RegWriteW, ResultSrcW, RdW}, 0);
        put(R_OP, 3'b000, 7'b0000000, 5'd1, 5'd2, 5'd3);
        tick(); tick();
        check("reset_hold_e", RegWriteE, 0);
        rst = 1'b1;

        // add x3,x1,x2 -> lui x4 -> jal x1
        put(R_OP, 3'b000, 7'b0000000, 5'd1, 5'd2, 5'd3);
        check("add_illegal", IllegalD, 0);
        check("add_stall", StallD, 0);
        tick();
        check("add_alu_e", ALUControlE, 4'b0000);
        check("add_rw_e", RegWriteE, 1);
        check("add_rd_e", RdE, 3);
        check("add_alusrc_e", ALUSrcE, 0);
        put(LUI_OP, 3'b000, 7'b0000000, 5'd0, 5'd0, 5'd4);
        check("lui_imm", ImmSrcD, 3'b100);
        tick();
        check("lui_alu_e", ALUControlE, 4'b1010);
        check("lui_alusrc_e", ALUSrcE, 1);
        check("add_rd_m", RdM, 3);
        check("add_rw_m", RegWriteM, 1);
        put(JAL_OP, 3'b000, 7'b0000000, 5'd0, 5'd0, 5'd1);
        check("jal_imm", ImmSrcD, 3'b011);
        tick();
        check("jal_jump_e", JumpE, 1);
        check("jal_res_e", ResultSrcE, 2'b10);
        check("jal_rd_e", RdE, 1);
        check("add_rw_w", RegWriteW, 1);
        check("add_rd_w", RdW, 3);
        check("lui_rd_m", RdM, 4);

        // ALU selection corner cases
        put(R_OP, 3'b000, 7'b0100000, 5'd1, 5'd2, 5'd6);
        tick();
        check("sub_alu_e", ALUControlE, 4'b0001);
        put(I_OP, 3'b101, 7'b0100000, 5'd1, 5'd0, 5'd6);
        tick();
        check("srai_alu_e", ALUControlE, 4'b1001);
        check("srai_alusrc_e", ALUSrcE, 1);
        put(I_OP, 3'b000, 7'b0100000, 5'd1, 5'd0, 5'd6);
        check("addi_imm", ImmSrcD, 3'b000);
        tick();
        check("addi_not_sub", ALUControlE, 4'b0000);
        put(R_OP, 3'b101, 7'b0000000, 5'd1, 5'd2, 5'd6);
        tick();
        check("srl_alu_e", ALUControlE, 4'b1000);
        put(R_OP, 3'b010, 7'b0100000, 5'd1, 5'd2, 5'd6);
        check("slt_alt_illegal", IllegalD, 1);

        // Load-use stall on Rs1
        put(LD_OP, 3'b010, 7'b0000000, 5'd1, 5'd0, 5'd5);
        tick();
        check("lw_res_e", ResultSrcE, 2'b01);
        check("lw_rw_e", RegWriteE, 1);
        put(R_OP, 3'b000, 7'b0000000, 5'd5, 5'd2, 5'd7);
        check("lu_stall_rs1", StallD, 1);
        tick();
        check_bubble("lu_bubble");
        check("lw_res_m", ResultSrcM, 2'b01);
        check("lw_rd_m", RdM, 5);
        check("lu_stall_clear", StallD, 0);
        tick();
        check("lu_resume_rw", RegWriteE, 1);
        check("lu_resume_rd", RdE, 7);

        // Load-use stall on Rs2 of a store; load to x0 never stalls
        put(LD_OP, 3'b010, 7'b0000000, 5'd1, 5'd0, 5'd8);
        tick();
        put(ST_OP, 3'b010, 7'b0000000, 5'd2, 5'd8, 5'd0);
        check("lu_stall_rs2", StallD, 1);
        check("sw_imm", ImmSrcD, 3'b001);
        put(LD_OP, 3'b010, 7'b0000000, 5'd1, 5'd0, 5'd0);
        tick();
        put(R_OP, 3'b000, 7'b0000000, 5'd0, 5'd0, 5'd9);
        check("lu_x0_nostall", StallD, 0);

        // Flush, and flush coinciding with stall
        put(BR_OP, 3'b000, 7'b0000000, 5'd1, 5'd2, 5'd0);
        check("beq_imm", ImmSrcD, 3'b010);
        FlushE = 1'b1;
        tick();
        check("flush_branch_e", BranchE, 0);
        check("flush_rw_e", RegWriteE, 0);
        FlushE = 1'b0;
        tick();
        check("beq_branch_e", BranchE, 1);
        check("beq_alu_e", ALUControlE, 4'b0001);
        put(LD_OP, 3'b010, 7'b0000000, 5'd1, 5'd0, 5'd9);
        tick();
        put(R_OP, 3'b000, 7'b0000000, 5'd3, 5'd9, 5'd10);
        FlushE = 1'b1;
        check("sf_stall", StallD, 1);
        tick();
        FlushE = 1'b0;
        check_bubble("sf_bubble");

        // M extension encoding and illegal opcodes
        put(R_OP, 3'b000, 7'b0000001, 5'd1, 5'd2, 5'd11);
`ifdef M_EXT_EN
        check("mul_illegal", IllegalD, 0);
        tick();
        check("mul_alu_e", ALUControlE, 4'b1011);
        put(R_OP, 3'b010, 7'b0000001, 5'd1, 5'd2, 5'd11);
        check("mulhsu_illegal", IllegalD, 1);
`else
        check("mul_illegal", IllegalD, 1);
        check("mul_imm", ImmSrcD, 3'b000);
        tick();
        check_bubble("mul_bubble");
`endif
        put(7'b1111111, 3'b000, 7'b0000000, 5'd1, 5'd2, 5'd12);
        check("badop_illegal", IllegalD, 1);
        tick();
        check_bubble("badop_bubble");

        // Rd=0 keeps RegWrite
        put(R_OP, 3'b110, 7'b0000000, 5'd1, 5'd2, 5'd0);
        tick();
        check("x0_rw_e", RegWriteE, 1);
        check("x0_alu_e", ALUControlE, 4'b0011);

        // Asynchronous reset with a store in Memory
        put(ST_OP, 3'b010, 7'b0000000, 5'd1, 5'd2, 5'd0);
        tick();
        put(R_OP, 3'b000, 7'b0000000, 5'd1, 5'd2, 5'd13);
        tick();
        check("sw_mw_m", MemWriteM, 1);
        rst = 1'b0;
        #1;
        check("async_mw_m", MemWriteM, 0);
        check("async_rw_e", RegWriteE, 0);
        check("async_rd_e", RdE, 0);
        check("async_rw_w", RegWriteW, 0);
        tick();
        rst = 1'b1;
        check("post_rst_rw_m", RegWriteM, 0);
        tick();
        check("post_rst_capture", RdE, 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
